// File: rtl/morse_pkg.sv
// morse_pkg: shared states, widths and character codes for the Morse sequencer
package morse_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
    localparam int PAT_W = 22;
    localparam int SEL_W = 4;
    localparam logic [SEL_W-1:0] CODE_SPACE = 4'h0;
    localparam logic [SEL_W-1:0] CODE_LAST = 4'hC;
endpackage

// File: rtl/secuenciador_morse_if.sv
// secuenciador_morse_if: character handshake, pattern mux select/return and key outputs
interface secuenciador_morse_if import morse_pkg::*;;
    logic             char_valid;
    logic [SEL_W-1:0] char_sel;
    logic             char_ready;
    logic [SEL_W-1:0] mux_sel;
    logic [PAT_W-1:0] patron;
    logic             tone;
    logic             busy;
    logic             done;
    modport master (output char_valid, char_sel, patron, input char_ready, mux_sel, tone, busy, done);
    modport slave (input char_valid, char_sel, patron, output char_ready, mux_sel, tone, busy, done);
endinterface

// File: rtl/secuenciador_morse_unit_timer.sv
// unit_timer: one-cycle tick every UNIT_CYCLES clocks, held at zero while clr is high
module unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int W = $clog2(UNIT_CYCLES);
    localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/secuenciador_morse.sv
// secuenciador_morse: selects a Morse pattern, keys it MSB-first per unit and appends a gap.
// Optional MORSE_ABORT_EN adds an abort input that returns to IDLE without done.
module secuenciador_morse import morse_pkg::*; #(
    parameter int UNIT_CYCLES = 12_500_000,
    parameter int CHAR_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS = 7
) (
    input logic clk,
    input logic rst_n,
`ifdef MORSE_ABORT_EN
    input logic abort,
`endif
    secuenciador_morse_if.slave bus
);
    localparam logic [2:0] CHAR_GAP = 3'(CHAR_GAP_UNITS - 1);
    localparam logic [2:0] WORD_GAP = 3'(WORD_GAP_UNITS - 1);
    state_t state;
    logic [PAT_W-1:0] sreg;
    logic [PAT_W-1:0] shifted;
    logic [4:0] bit_cnt;
    logic [2:0] gap_cnt;
    logic tick;
    logic clr;
    logic kill;
`ifdef MORSE_ABORT_EN
    assign kill = abort && state != IDLE;
`else
    assign kill = 1'b0;
`endif
    // timer sits at zero outside SHIFT/GAP so every keyed unit starts aligned
    assign clr = state == IDLE || state == LOAD || kill;
    assign shifted = sreg << 1;
    assign bus.tone = state == SHIFT && sreg[PAT_W-1];
    unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (.clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick));
    always_ff @(posedge clk) begin
        if (!rst_n || kill) begin
            state <= IDLE;
            sreg <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.char_ready <= 1'b1;
            if (!rst_n) bus.mux_sel <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.char_valid && bus.char_ready) begin
                    bus.mux_sel <= bus.char_sel;
                    state <= LOAD;
                    bus.busy <= 1'b1;
                    bus.char_ready <= 1'b0;
                end
                LOAD: begin
                    sreg <= bus.patron;
                    bit_cnt <= '0;
                    state <= bus.patron == '0 ? GAP : SHIFT;
                    gap_cnt <= WORD_GAP;
                end
                SHIFT: if (tick) begin
                    sreg <= shifted;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (shifted == '0 || bit_cnt == 5'(PAT_W - 1)) begin
                        state <= GAP;
                        gap_cnt <= CHAR_GAP;
                    end
                end
                GAP: if (tick) begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        bus.char_ready <= 1'b1;
                    end else gap_cnt <= gap_cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secuenciador_morse.sv
// tb_secuenciador_morse: randomized characters checked against a per-cycle Morse timing model
module tb_secuenciador_morse;
    import morse_pkg::*;
    localparam int UC = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    logic [PAT_W-1:0] pat_tab [16];
    secuenciador_morse_if bus ();
    secuenciador_morse #(.UNIT_CYCLES(UC), .CHAR_GAP_UNITS(3), .WORD_GAP_UNITS(7)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MORSE_ABORT_EN
        .abort(abort),
`endif
        .bus(bus)
    );
    always #5 clk = ~clk;
    always_comb bus.patron = pat_tab[bus.mux_sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: run to done; 1: reset inside SHIFT; 2: abort inside GAP; 3: reset anywhere
    task automatic run_char(input logic [3:0] code, input int mode);
        logic [PAT_W-1:0] p;
        int n, g, len, cut;
        p = pat_tab[code];
        n = 0;
        for (int i = 0; i < PAT_W; i++) if (p[PAT_W-1-i]) n = i + 1;
        g = (p == '0) ? 7 : 3;
        len = 2 + (n + g) * UC;
        cut = 0;
        if (mode == 1) cut = (n > 0) ? $urandom_range(1 + n * UC, 2) : 2;
        if (mode == 2) cut = $urandom_range(len - 1, 2 + n * UC);
        if (mode == 3) cut = $urandom_range(len, 2);
        chk("ready_before", 32'(bus.char_ready), 1);
        bus.char_valid = 1'b1;
        bus.char_sel = code;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) chk("mux_sel", 32'(bus.mux_sel), 32'(code));
            chk("tone", 32'(bus.tone), (k >= 2 && k < 2 + n * UC) ? 32'(p[PAT_W-1-(k-2)/UC]) : 0);
            chk("busy", 32'(bus.busy), 32'(k < len));
            chk("done", 32'(bus.done), 32'(k == len));
            chk("ready", 32'(bus.char_ready), 32'(k == len));
            if (k == 3 && code != CODE_SPACE && code <= CODE_LAST) pat_tab[code] = PAT_W'($urandom);
            if (k == cut) begin
                bus.char_valid = 1'b0;
                if (mode == 2) abort = 1'b1;
                else rst_n = 1'b0;
                @(negedge clk);
                chk("cut_tone", 32'(bus.tone), 0);
                chk("cut_busy", 32'(bus.busy), 0);
                chk("cut_done", 32'(bus.done), 0);
                chk("cut_ready", 32'(bus.char_ready), 1);
                if (mode != 2) chk("cut_mux_sel", 32'(bus.mux_sel), 0);
                abort = 1'b0;
                rst_n = 1'b1;
                @(negedge clk);
                chk("cut_done_after", 32'(bus.done), 0);
                chk("cut_busy_after", 32'(bus.busy), 0);
                return;
            end
            if (k < len) begin
                bus.char_valid = 1'($urandom);
                bus.char_sel = 4'($urandom);
            end
        end
    endtask

    task automatic idle_cycles(input int c);
        bus.char_valid = 1'b0;
        for (int i = 0; i < c; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(bus.busy), 0);
            chk("idle_tone", 32'(bus.tone), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pat_tab[i] = (i == 0 || i > 12) ? '0 : PAT_W'($urandom);
        pat_tab[1] = 22'h200000;
        pat_tab[2] = 22'h2E0000;
        bus.char_valid = 1'b0;
        bus.char_sel = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_tone", 32'(bus.tone), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ready", 32'(bus.char_ready), 1);
        chk("rst_mux_sel", 32'(bus.mux_sel), 0);
        run_char(4'd1, 0);
        run_char(4'd2, 0);
        idle_cycles(2);
        run_char(4'd0, 0);
        idle_cycles(1);
        pat_tab[2] = 22'h2E0000;
        run_char(4'd2, 1);
        run_char(4'd1, 0);
`ifdef MORSE_ABORT_EN
        idle_cycles(1);
        run_char(4'd2, 2);
        run_char(4'd1, 0);
`endif
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = ($urandom_range(4, 0) == 0) ? 3 : 0;
`ifdef MORSE_ABORT_EN
            if (mode == 0 && $urandom_range(5, 0) == 0) mode = 2;
`endif
            run_char(4'($urandom), mode);
            if ($urandom_range(1, 0) == 1) idle_cycles($urandom_range(3, 1));
        end
        idle_cycles(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
